cb_seg_bcast: RTL
=================

# cb_seg_bcast

Parametrised code-block segmentation engine and successor to the current fixed-width segmenter. It takes a transport-block byte stream and a precomputed segmentation descriptor (C, C−, K+, K−, F), then emits code blocks byte-serially: filler, payload, and a per-CB CRC24B when C>1. Every beat is broadcast to NUM_OUT downstream consumers (interleaver, encoder, …), each with independent ready backpressure. It sits between the TB input FIFO / size calculator and the channel-coding FIFOs.

## Interface
Parameters:
- KW, 10: width of CB and filler byte counts (max K = 2^KW−1 bytes).
- CW, 6: width of the CB count and CB index.
- NUM_OUT, 2: number of broadcast consumers (≥1).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- desc_valid / desc_ready  in / out  1 / 1  descriptor handshake.
- desc_c  in  CW  CB count C (≥1).
- desc_c_minus  in  CW  number of leading K− blocks (≤ C).
- desc_k_plus, desc_k_minus  in  KW  CB sizes in bytes, including the CRC.
- desc_f  in  KW  filler bytes, placed in the first CB only.
- in_valid / in_ready  in / out  1 / 1  TB byte stream handshake.
- in_data  in  8  TB byte.
- out_valid  out  NUM_OUT  per-consumer beat valid.
- out_ready  in  NUM_OUT  per-consumer ready.
- out_data  out  8  CB byte (filler 0x00, payload, or CRC MSB-first).
- out_sop, out_eop  out  1  first / last byte of a CB.
- out_size  out  1  1 = K+ block, 0 = K− block.
- out_tb_end  out  1  last byte of the last CB.
- out_cb_idx  out  CW  CB index of the current beat.
- desc_err  out  1  one-cycle pulse on descriptor rejection.
- busy  out  1  high from descriptor accept until the last beat is fully taken.

## Operation
- States: IDLE → CHECK → FILL → DATA → CRC → (next CB: FILL-skip → DATA, or done → IDLE).
- IDLE:
  - desc_ready=1.
  - On handshake, latch the descriptor and go to CHECK.
- CHECK (1 cycle): reject when any of the following holds:
  - C=0;
  - C−>C;
  - C>1 and the first-CB size ≤ 3+F;
  - C=1 and K ≤ F.
- On reject: pulse desc_err, return to IDLE, emit nothing.
- CB j uses K− if j < C−, otherwise K+.
- Payload bytes for CB j = K − 3·(C>1) − F·(j==0).
- FILL: emit F bytes of 0x00 (first CB only). in_ready=0.
- DATA:
  - in_ready = output slot free.
  - Each accepted input byte becomes one beat.
- CRC (only when C>1):
  - Emit 3 bytes, MSB first.
  - CRC24B, polynomial 0x800063, initialised to 0 at every CB sop.
  - Covers filler + payload bytes of that CB.
- out_sop on the first beat of each CB; out_eop on its last; out_tb_end coincides with eop of CB C−1.
- Broadcast:
  - Internal taken[NUM_OUT] mask.
  - out_valid[i] = beat_valid & ~taken[i].
  - A beat retires when, for every i, out_ready[i] | taken[i] holds.
  - On retire the mask clears; otherwise taken[i] is set for every i with out_valid[i] & out_ready[i].
  - Each consumer sees each beat exactly once, in order.
- Input bubbles (in_valid=0) stall DATA. No gap bytes are emitted and the CRC is unaffected.

## Timing
- Reset values:
  - desc_ready=0 during reset, then 1 in IDLE.
  - All out_* = 0, desc_err=0, busy=0, in_ready=0, taken=0.
- Descriptor accepted in cycle T: CHECK in T+1; first out_valid in T+2 (FILL), or T+2 plus input latency if F=0.
- Output is registered: in_data accepted in cycle t appears on out_data in t+1.
- Throughput is 1 byte/cycle when all consumers are ready and input is continuous. No bubbles at FILL→DATA, DATA→CRC, or CRC→next-CB boundaries.
- The first CRC byte is valid in the cycle after the last payload beat is loaded; the CRC register updates on beat load, not retire.
- desc_ready stays 0 while busy. A back-to-back descriptor is accepted the cycle after the final beat retires.
- Reset asserted mid-operation: immediate asynchronous clear to IDLE. The partial CB is discarded and no eop is emitted.

## Structure
- Package cb_seg_bcast_pkg holds:
  - CRC_BYTES=3;
  - CRC24B_POLY=24'h800063;
  - the state enum;
  - a function returning CB size for index j.
- One sub-module, crc24b_byte: 8-bit-parallel CRC24B register with init/enable, 24-bit output. This is the natural split.
- Broadcast mask logic stays inline.

## Test plan
- C=1, K+=40, F=0, 40 input bytes 0x00..0x27, all ready → 40 beats identical to input; sop on beat 1; eop+tb_end on beat 40; no CRC bytes.
- C=2, C−=1, K−=8, K+=10, F=2, input 0x01..0x0A:
  - 18 beats: 00 00 01 02 03 CRC(3), then 04..0A CRC(3).
  - CRCs match the golden CRC24B model.
  - out_size 0 for CB0, 1 for CB1.
  - out_cb_idx 0 then 1.
- NUM_OUT=2, out_ready[0]=1, out_ready[1] toggling every cycle on case 2 → both consumers log identical 18-byte sequences with no duplicates; retire rate 1 per 2 cycles.
- Case 2 with in_valid low every third cycle → same 18-byte output, with stalls visible only as out_valid gaps.
- Descriptor C=2, K−=K+=5, F=2 (first CB ≤ 3+F) → desc_err pulse at T+1, no out_valid, desc_ready=1 at T+2.
- Reset driven low during the second CRC byte of case 2 → all outputs 0 in the same cycle. After release, case 1 runs and produces the exact expected 40 beats.

Source files
------------

// File: rtl/cb_seg_bcast_pkg.sv
// Shared types and constants for the code-block segmentation engine.
// Holds the CRC24B constants, FSM state encoding and the per-CB size rule.
package cb_seg_bcast_pkg;

  localparam int unsigned CRC_BYTES   = 3;
  localparam logic [23:0] CRC24B_POLY = 24'h800063;
  localparam int unsigned SZ_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FILL,
    ST_DATA,
    ST_CRC,
    ST_DRAIN
  } seg_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       size;
    logic       tb_end;
  } beat_t;

  // Leading C- blocks use K-, the remainder use K+.
  function automatic logic [SZ_W-1:0] cb_size(input logic [SZ_W-1:0] j,
                                               input logic [SZ_W-1:0] c_minus,
                                               input logic [SZ_W-1:0] k_minus,
                                               input logic [SZ_W-1:0] k_plus);
    return (j < c_minus) ? k_minus : k_plus;
  endfunction

endpackage

// File: rtl/cb_seg_bcast_crc.sv
// Byte-parallel CRC24B register (poly 0x800063, MSB first, zero init).
module crc24b_byte
  import cb_seg_bcast_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [23:0] crc
);

  logic [23:0] crc_q;
  logic [23:0] crc_d;
  logic [23:0] seed;

  function automatic logic [23:0] crc_step(input logic [23:0] c, input logic [7:0] d);
    logic [23:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[23] ^ d[i]) r = (r << 1) ^ CRC24B_POLY;
      else              r = r << 1;
    end
    return r;
  endfunction

  // init together with en folds the first byte of a block into a fresh register.
  always_comb begin
    seed  = init ? 24'h0 : crc_q;
    crc_d = crc_q;
    if (en)        crc_d = crc_step(seed, data);
    else if (init) crc_d = 24'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) crc_q <= 24'h0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/cb_seg_bcast.sv
// Code-block segmentation engine: filler + payload + per-CB CRC24B,
// each beat broadcast once to NUM_OUT independently back-pressured consumers.
module cb_seg_bcast
  import cb_seg_bcast_pkg::*;
#(
  parameter int unsigned KW      = 10,
  parameter int unsigned CW      = 6,
  parameter int unsigned NUM_OUT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [CW-1:0]      desc_c,
  input  logic [CW-1:0]      desc_c_minus,
  input  logic [KW-1:0]      desc_k_plus,
  input  logic [KW-1:0]      desc_k_minus,
  input  logic [KW-1:0]      desc_f,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [7:0]         out_data,
  output logic               out_sop,
  output logic               out_eop,
  output logic               out_size,
  output logic               out_tb_end,
  output logic [CW-1:0]      out_cb_idx,
  output logic               desc_err,
  output logic               busy
);

  localparam int unsigned KX = KW + 1;

  seg_state_e         state_q, state_d;
  logic [CW-1:0]      c_q, c_d, cm_q, cm_d;
  logic [KW-1:0]      kp_q, kp_d, km_q, km_d, f_q, f_d;
  logic [CW-1:0]      cur_cb_q, cur_cb_d;
  logic [KW-1:0]      pos_q, pos_d;
  logic               beat_valid_q, beat_valid_d;
  beat_t              beat_q, beat_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] taken_q, taken_d;
  logic               desc_ready_q, desc_ready_d;
  logic               desc_err_q, desc_err_d;
  logic               busy_q, busy_d;

  logic [KW-1:0]      first_k_in;
  logic               chk_err;
  logic [KW-1:0]      k_cur;
  logic [KW-1:0]      crc_n;
  logic [KW-1:0]      crc_left;
  logic               last_in_cb;
  logic               is_last_cb;
  logic               retire;
  logic               slot_free;
  logic               ld_go;
  logic [7:0]         ld_data;
  logic               crc_init;
  logic               crc_en;
  logic [23:0]        crc;

  // Descriptor legality is judged on the raw inputs so the error pulse lines up with CHECK.
  assign first_k_in = KW'(cb_size('0, SZ_W'(desc_c_minus), SZ_W'(desc_k_minus), SZ_W'(desc_k_plus)));
  assign chk_err = (desc_c == '0) || (desc_c_minus > desc_c) ||
                   ((desc_c > CW'(1)) && (KX'(first_k_in) <= (KX'(desc_f) + KX'(CRC_BYTES)))) ||
                   ((desc_c == CW'(1)) && (first_k_in <= desc_f));

  assign k_cur      = KW'(cb_size(SZ_W'(cur_cb_q), SZ_W'(cm_q), SZ_W'(km_q), SZ_W'(kp_q)));
  assign crc_n      = (c_q > CW'(1)) ? KW'(CRC_BYTES) : '0;
  assign crc_left   = k_cur - pos_q;
  assign last_in_cb = (pos_q == (k_cur - KW'(1)));
  assign is_last_cb = (cur_cb_q == (c_q - CW'(1)));

  assign out_valid = {NUM_OUT{beat_valid_q}} & ~taken_q;
  assign retire    = beat_valid_q & (&(out_ready | taken_q));
  assign slot_free = ~beat_valid_q | retire;
  assign in_ready  = (state_q == ST_DATA) & slot_free;

  // Which section the byte at (cb, pos) belongs to.
  function automatic seg_state_e phase_of(input logic [CW-1:0] cb, input logic [KW-1:0] pos);
    logic [KW-1:0] k;
    logic [KW-1:0] fcur;
    k    = KW'(cb_size(SZ_W'(cb), SZ_W'(cm_q), SZ_W'(km_q), SZ_W'(kp_q)));
    fcur = (cb == '0) ? f_q : '0;
    if (pos < fcur) return ST_FILL;
    if ((KX'(pos) + KX'(crc_n)) < KX'(k)) return ST_DATA;
    return ST_CRC;
  endfunction

  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    cm_d         = cm_q;
    kp_d         = kp_q;
    km_d         = km_q;
    f_d          = f_q;
    cur_cb_d     = cur_cb_q;
    pos_d        = pos_q;
    desc_err_d   = 1'b0;
    ld_go        = 1'b0;
    ld_data      = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (desc_valid && desc_ready_q) begin
          c_d        = desc_c;
          cm_d       = desc_c_minus;
          kp_d       = desc_k_plus;
          km_d       = desc_k_minus;
          f_d        = desc_f;
          cur_cb_d   = '0;
          pos_d      = '0;
          desc_err_d = chk_err;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // The first filler byte is loaded here so FILL starts without a bubble.
        if (desc_err_q)        state_d = ST_IDLE;
        else if (f_q != '0)    ld_go   = 1'b1;
        else                   state_d = phase_of(cur_cb_q, pos_q);
      end
      ST_FILL: begin
        ld_go = slot_free;
      end
      ST_DATA: begin
        ld_go   = in_ready & in_valid;
        ld_data = in_data;
      end
      ST_CRC: begin
        ld_go = slot_free;
        case (crc_left)
          KW'(3):  ld_data = crc[23:16];
          KW'(2):  ld_data = crc[15:8];
          default: ld_data = crc[7:0];
        endcase
      end
      ST_DRAIN: begin
        if (retire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ld_go) begin
      if (last_in_cb) begin
        if (is_last_cb) begin
          state_d = ST_DRAIN;
        end else begin
          cur_cb_d = cur_cb_q + CW'(1);
          pos_d    = '0;
          state_d  = phase_of(cur_cb_q + CW'(1), '0);
        end
      end else begin
        pos_d   = pos_q + KW'(1);
        state_d = phase_of(cur_cb_q, pos_q + KW'(1));
      end
    end
  end

  // Output slot and broadcast mask.
  always_comb begin
    beat_valid_d = ld_go | (beat_valid_q & ~retire);
    beat_d       = beat_q;
    idx_d        = idx_q;
    if (ld_go) begin
      beat_d.data   = ld_data;
      beat_d.sop    = (pos_q == '0);
      beat_d.eop    = last_in_cb;
      beat_d.size   = ~(cur_cb_q < cm_q);
      beat_d.tb_end = last_in_cb & is_last_cb;
      idx_d         = cur_cb_q;
    end
    taken_d      = retire ? '0 : (taken_q | (out_valid & out_ready));
    desc_ready_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
  end

  assign crc_init = ld_go & (pos_q == '0);
  assign crc_en   = ld_go & ((state_q == ST_CHECK) || (state_q == ST_FILL) || (state_q == ST_DATA));

  crc24b_byte u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (crc_init),
    .en    (crc_en),
    .data  (ld_data),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      c_q          <= '0;
      cm_q         <= '0;
      kp_q         <= '0;
      km_q         <= '0;
      f_q          <= '0;
      cur_cb_q     <= '0;
      pos_q        <= '0;
      beat_valid_q <= 1'b0;
      beat_q       <= '0;
      idx_q        <= '0;
      taken_q      <= '0;
      desc_ready_q <= 1'b0;
      desc_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      cm_q         <= cm_d;
      kp_q         <= kp_d;
      km_q         <= km_d;
      f_q          <= f_d;
      cur_cb_q     <= cur_cb_d;
      pos_q        <= pos_d;
      beat_valid_q <= beat_valid_d;
      beat_q       <= beat_d;
      idx_q        <= idx_d;
      taken_q      <= taken_d;
      desc_ready_q <= desc_ready_d;
      desc_err_q   <= desc_err_d;
      busy_q       <= busy_d;
    end
  end

  assign desc_ready = desc_ready_q;
  assign desc_err   = desc_err_q;
  assign busy       = busy_q;
  assign out_data   = beat_q.data;
  assign out_sop    = beat_q.sop;
  assign out_eop    = beat_q.eop;
  assign out_size   = beat_q.size;
  assign out_tb_end = beat_q.tb_end;
  assign out_cb_idx = idx_q;

endmodule
